eb_rr_arb: RTL

EB_RR_ARB -- requirements
Module: eb_rr_arb

---
 rtl/eb_arb_pkg.sv | 38 +++
 rtl/eb2_stage.sv | 53 +++++
 rtl/eb_rr_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/eb_arb_pkg.sv
// Shared state encoding and round-robin search for the packet-locking merge arbiter.
package eb_arb_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_LOCK = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First requester at or above ptr (wrapping at n); the descending loop lets the nearest one win.
    function automatic rr_pick_t rr_search(input logic [MAX_N-1:0] req,
                                           input logic [3:0]       ptr,
                                           input int               n);
        rr_pick_t   pick;
        int         k;
        logic [3:0] idx;
        pick = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                idx = 4'(k);
                if (req[idx]) begin
                    pick.found = 1'b1;
                    pick.idx   = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/eb2_stage.sv
// Two-entry elastic buffer: registered outputs, one-cycle latency, full throughput.
module eb2_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic             r_out_vld;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_load_out;

    // Ready comes from a register so it never depends on i_ready; forced low while in reset.
    assign o_ready    = reset_n & ~r_skid_vld;
    assign w_in_fire  = i_valid & o_ready;
    assign w_load_out = ~r_out_vld | i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else if (w_load_out) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_skid_data;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= w_in_fire;
                if (w_in_fire) r_out_data <= i_data;
            end
        end else if (w_in_fire) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= i_data;
        end
    end

    assign o_valid = r_out_vld;
    assign o_data  = r_out_data;
    assign o_busy  = r_out_vld;

endmodule

// File: rtl/eb_rr_arb.sv
// Round-robin merge of N_IN packet streams into one, holding the grant for a whole packet.
module eb_rr_arb
    import eb_arb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int WIDTH = 32,
    parameter int SW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_IN-1:0]       t_valid,
    output logic [N_IN-1:0]       t_ready,
    input  logic [N_IN*WIDTH-1:0] t_data,
    input  logic [N_IN-1:0]       t_last,
    output logic                  i_valid,
    input  logic                  i_ready,
    output logic [WIDTH-1:0]      i_data,
    output logic                  i_last,
    output logic [SW-1:0]         i_src,
    output logic                  busy
);

    localparam int PW = WIDTH + 1 + SW;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SW-1:0]    r_gnt;
    logic [SW-1:0]    w_gnt_nxt;
    logic [SW-1:0]    r_ptr;
    logic [SW-1:0]    w_ptr_nxt;
    logic [SW-1:0]    w_win;
    logic             w_win_ok;
    logic             w_stage_ready;
    logic             w_acc;
    logic             w_last;
    logic             w_occupied;
    logic [WIDTH-1:0] w_data;
    logic [PW-1:0]    w_pay_out;
    rr_pick_t         w_pick;

    assign w_pick = rr_search(MAX_N'(t_valid), 4'(r_ptr), N_IN);

    always_comb begin
        w_win    = r_gnt;
        w_win_ok = 1'b1;
        if (r_state == ST_IDLE) begin
            w_win    = SW'(w_pick.idx);
            w_win_ok = w_pick.found;
        end
    end

    always_comb begin
        t_ready = '0;
        if (w_win_ok && w_stage_ready) t_ready[w_win] = 1'b1;
    end

    assign w_acc  = w_win_ok & w_stage_ready & t_valid[w_win];
    assign w_last = t_last[w_win];
    assign w_data = t_data[int'(w_win)*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && !w_last) begin
                    w_state_nxt = ST_LOCK;
                    w_gnt_nxt   = w_win;
                end
            end
            ST_LOCK: begin
                if (w_acc && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Any completed packet, single-beat or not, moves priority past its source.
        if (w_acc && w_last) w_ptr_nxt = (w_win == SW'(N_IN - 1)) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    eb2_stage #(.WIDTH(PW)) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_acc),
        .o_ready (w_stage_ready),
        .i_data  ({w_data, w_last, w_win}),
        .o_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (w_pay_out),
        .o_busy  (w_occupied)
    );

    assign {i_data, i_last, i_src} = w_pay_out;
    assign busy = (r_state == ST_LOCK) | w_occupied;

endmodule
